// File: rtl/ascon_host_ctrl.sv
// Host-side sequencer for the ASCON-128 core: start, AD word, plaintext stream,
// ciphertext return, tag capture and a watchdog on every core wait.
module ascon_host_ctrl #(
    parameter int MAX_BLOCKS = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          req_i,
    input  logic [127:0]  key_i,
    input  logic [127:0]  nonce_i,
    input  logic [63:0]   ad_i,
    input  logic [7:0]    n_blocks_i,
    input  logic          pt_valid_i,
    input  logic [63:0]   pt_data_i,
    output logic          pt_ready_o,
    output logic          ct_valid_o,
    output logic [63:0]   ct_data_o,
    output logic          tag_valid_o,
    output logic [127:0]  tag_o,
    output logic          busy_o,
    output logic          err_o,
    output logic          start_o,
    output logic          data_valid_o,
    output logic [63:0]   data_o,
    output logic [127:0]  key_o,
    output logic [127:0]  nonce_o,
    input  logic          cipher_valid_i,
    input  logic          end_i,
    input  logic [63:0]   cipher_i,
    input  logic [127:0]  tag_i
);

    typedef enum logic [2:0] {
        IDLE, START, SEND_AD, WAIT_AD, GET_PT, WAIT_CT, WAIT_END
    } state_e;

    localparam logic [7:0]  MaxBlk = 8'(MAX_BLOCKS);
    localparam logic [15:0] WdLim  = 16'(TIMEOUT - 1);

    state_e         state_q;
    logic [127:0]   key_q;
    logic [127:0]   nonce_q;
    logic [63:0]    data_q;
    logic [7:0]     nblk_q;
    logic [7:0]     cnt_q;
    logic [15:0]    wd_q;
    logic           err_q;
    logic           ct_valid_q;
    logic [63:0]    ct_data_q;
    logic           tag_valid_q;
    logic [127:0]   tag_q;
    logic           wd_hit;
    logic           pt_pass;

    assign wd_hit  = (wd_q == WdLim);
    assign pt_pass = (state_q == GET_PT) && pt_valid_i;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q     <= IDLE;
            key_q       <= '0;
            nonce_q     <= '0;
            data_q      <= '0;
            nblk_q      <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            ct_valid_q  <= 1'b0;
            ct_data_q   <= '0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            err_q       <= 1'b0;
            ct_valid_q  <= 1'b0;
            tag_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (req_i) begin
                        key_q   <= key_i;
                        nonce_q <= nonce_i;
                        data_q  <= ad_i;
                        nblk_q  <= n_blocks_i;
                        cnt_q   <= '0;
                        if (n_blocks_i == 8'd0 || n_blocks_i > MaxBlk)
                            err_q <= 1'b1;
                        else
                            state_q <= START;
                    end
                end
                START: state_q <= SEND_AD;
                SEND_AD: begin
                    state_q <= WAIT_AD;
                    wd_q    <= '0;
                end
                WAIT_AD: begin
                    if (cipher_valid_i) begin
                        state_q <= GET_PT;
                        wd_q    <= '0;
                    end else if (wd_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                GET_PT: begin
                    if (pt_valid_i) begin
                        data_q  <= pt_data_i;
                        state_q <= WAIT_CT;
                        wd_q    <= '0;
                    end
                end
                WAIT_CT: begin
                    // a same-cycle end_i on the last block is dropped here
                    if (cipher_valid_i) begin
                        ct_valid_q <= 1'b1;
                        ct_data_q  <= cipher_i;
                        cnt_q      <= cnt_q + 8'd1;
                        wd_q       <= '0;
                        if (cnt_q + 8'd1 == nblk_q)
                            state_q <= WAIT_END;
                        else
                            state_q <= GET_PT;
                    end else if (wd_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                WAIT_END: begin
                    if (end_i) begin
                        tag_q       <= tag_i;
                        tag_valid_q <= 1'b1;
                        state_q     <= IDLE;
                        wd_q        <= '0;
                    end else if (wd_hit) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pt_ready_o   = (state_q == GET_PT);
    assign start_o      = (state_q == START);
    assign busy_o       = (state_q != IDLE);
    assign data_valid_o = (state_q == SEND_AD) || pt_pass;
    assign data_o       = pt_pass ? pt_data_i : data_q;
    assign key_o        = key_q;
    assign nonce_o      = nonce_q;
    assign err_o        = err_q;
    assign ct_valid_o   = ct_valid_q;
    assign ct_data_o    = ct_data_q;
    assign tag_valid_o  = tag_valid_q;
    assign tag_o        = tag_q;

endmodule

// File: doc/ascon_host_ctrl.md
# ascon_host_ctrl

Host-side sequencer for the ASCON-128 encryption core `ascon_top`, acting as the driving end of its start/data_valid/cipher_valid/end interface. It accepts a job (key, nonce, one associated-data word, N plaintext words), issues the start pulse, feeds each 64-bit word, and collects each ciphertext word and the final 128-bit tag. It returns ciphertext and tag to the host on simple valid strobes and flags a watchdog timeout if the core stalls.

## Interface
- MAX_BLOCKS, 8: maximum plaintext words per job; range 1..255.
- TIMEOUT, 1024: cycles allowed between a driver request and the core's response before error.
- clock_i  in  1  single clock, rising-edge.
- resetb_i  in  1  asynchronous, active-low reset.
- req_i  in  1  job request; sampled only in IDLE.
- key_i  in  128  key; captured on accepted req_i.
- nonce_i  in  128  nonce; captured on accepted req_i.
- ad_i  in  64  associated-data word; captured on accepted req_i.
- n_blocks_i  in  8  plaintext word count; captured on accepted req_i.
- pt_valid_i  in  1  host plaintext word valid.
- pt_data_i  in  64  host plaintext word.
- pt_ready_o  out  1  driver accepts plaintext word this cycle.
- ct_valid_o  out  1  one-cycle strobe: ct_data_o valid.
- ct_data_o  out  64  ciphertext word.
- tag_valid_o  out  1  one-cycle strobe: tag_o valid, job done.
- tag_o  out  128  captured tag; holds until next tag_valid_o.
- busy_o  out  1  job in progress.
- err_o  out  1  one-cycle strobe: job aborted (bad count or timeout).
- start_o  out  1  to core start_i.
- data_valid_o  out  1  to core data_valid_i.
- data_o  out  64  to core data_i.
- key_o, nonce_o  out  128 each  to core key_i/nonce_i; registered copies.
- cipher_valid_i  in  1  from core cipher_valid_o.
- end_i  in  1  from core end_o.
- cipher_i  in  64  from core cipher_o.
- tag_i  in  128  from core tag_o.

## Operation
- Core protocol, fixed: one start_o pulse with key_o/nonce_o stable; per data word one data_valid_o pulse with data_o stable until the core acknowledges with cipher_valid_i. The AD word is sent first and acknowledged too; its cipher_i is discarded. end_i pulses once after the last plaintext acknowledgement, with tag_i valid in that cycle.
- States: IDLE, START, SEND_AD, WAIT_AD, GET_PT, WAIT_CT, WAIT_END.
- IDLE: on req_i, capture inputs. If n_blocks_i is 0 or greater than MAX_BLOCKS, pulse err_o and stay in IDLE. Otherwise go to START.
- START: start_o=1 for one cycle -> SEND_AD.
- SEND_AD: data_o=ad word, data_valid_o=1 for one cycle -> WAIT_AD.
- WAIT_AD: on cipher_valid_i -> GET_PT.
- GET_PT: pt_ready_o=1. On pt_valid_i, data_o=pt_data_i, data_valid_o=1 in that same cycle (combinational pass), and data_o is registered for hold -> WAIT_CT.
- WAIT_CT: on cipher_valid_i, drive ct_data_o=cipher_i and pulse ct_valid_o next cycle; increment block count. If count equals n_blocks -> WAIT_END, else -> GET_PT.
- WAIT_END: on end_i, register tag_i, pulse tag_valid_o next cycle -> IDLE.
- Watchdog: a 16-bit counter clears on every state change and counts in WAIT_AD, WAIT_CT and WAIT_END. On reaching TIMEOUT, pulse err_o and go to IDLE; no tag_valid_o.
- Stray cipher_valid_i or end_i in any state not waiting for it: ignored.
- busy_o=1 in every state except IDLE.

## Timing
- Reset: all outputs 0, tag_o=0, key_o/nonce_o=0, state IDLE, counters 0. Reset mid-job aborts the job with no strobe.
- req_i accepted at edge k: start_o high in cycle k+1, AD data_valid_o in cycle k+2.
- pt_ready_o is high only in GET_PT. Only one word is outstanding at a time, so there is no buffering.
- ct_valid_o and tag_valid_o come one cycle after cipher_valid_i and end_i respectively.
- If end_i and cipher_valid_i arrive in the same cycle in WAIT_CT on the last block: take the ciphertext, then go to WAIT_END. That end_i is not counted.

## Test plan
- Bench core model returns cipher = data XOR 64'hFFFF_FFFF_FFFF_FFFF after 5 cycles and tag = {key, nonce} XOR pattern. Job with key 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF, nonce 128'h4ED0EC0B98C529B7C8CDDF37BCD0284A, ad 64'h4120746F2042, n=1, pt 64'h0 -> one start_o, two data_valid_o, ct_data_o=64'hFFFF_FFFF_FFFF_FFFF, then tag_valid_o.
- n=3 with pt_valid_i stalled 4 cycles between words -> three ct_valid_o in order; pt_ready_o only high while waiting.
- n_blocks_i=0 and n_blocks_i=MAX_BLOCKS+1 -> err_o pulse one cycle after req_i; start_o never asserted.
- Core never answers the AD word -> err_o exactly TIMEOUT cycles after entering WAIT_AD, busy_o drops, and the next job succeeds.
- resetb_i asserted during WAIT_CT -> all outputs 0 immediately; no ct_valid_o or tag_valid_o afterwards.
